round_ctrl: RTL and testbench

//  Game-round sequencer that owns the shared timer instance: configures it, pulses its reset, gates enable.

---
 rtl/round_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_round_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_ctrl.sv
// round_ctrl: game-round sequencer that owns the shared timer.
// Each round opens a response window, which is the timer at the latched difficulty
// counting to WINDOW_END. The window is followed by an inter-round gap, which is the
// timer at difficulty 0 counting to GAP_END. The block scores hits and misses.
// Every output is registered, and shows the values of the state that was just entered.
// Optional feature macro: ROUND_CTRL_BEST_EN adds the last_time and best_time
// reaction-time outputs.
module round_ctrl #(
    parameter int ROUNDS     = 10,
    parameter int WINDOW_END = 1000,
    parameter int GAP_END    = 500,
    parameter int SCORE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         difficulty_sel,
    input  logic               response,
    input  logic [11:0]        timer_value,
    input  logic               end_reached,
    output logic               timer_reset,
    output logic               timer_enable,
    output logic [1:0]         timer_difficulty,
    output logic [11:0]        timer_end_value,
    output logic               round_active,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] round_num,
    output logic               game_over
`ifdef ROUND_CTRL_BEST_EN
    ,
    output logic [11:0]        last_time,
    output logic [11:0]        best_time
`endif
);

    localparam logic [11:0]        WIN_END_C = 12'(WINDOW_END);
    localparam logic [11:0]        GAP_END_C = 12'(GAP_END);
    localparam logic [SCORE_W-1:0] ROUNDS_C  = SCORE_W'(ROUNDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM_WIN,
        S_RUN,
        S_RESULT,
        S_ARM_GAP,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         dif_q, dif_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [SCORE_W-1:0] round_q, round_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               tr_q, tr_d;
    logic               en_q, en_d;
    logic [1:0]         tdif_q, tdif_d;
    logic [11:0]        tend_q, tend_d;
    logic               ra_q, ra_d;
    logic               go_q, go_d;

`ifdef ROUND_CTRL_BEST_EN
    logic [11:0]        last_q, last_d;
    logic [11:0]        best_q, best_d;
`else
    // The reaction-time sample is consumed only when the best-time feature is built in.
    logic               unused_timer_value;
    assign unused_timer_value = ^timer_value;
`endif

    // Next-state, scoring and registered-output decode for the state being entered.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d = state_q;
        dif_d   = dif_q;
        score_d = score_q;
        round_d = round_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
`ifdef ROUND_CTRL_BEST_EN
        last_d  = last_q;
        best_d  = best_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dif_d   = difficulty_sel;
                    score_d = '0;
                    round_d = '0;
`ifdef ROUND_CTRL_BEST_EN
                    last_d  = 12'hFFF;
                    best_d  = 12'hFFF;
`endif
                    state_d = S_ARM_WIN;
                end
            end
            S_ARM_WIN: state_d = S_RUN;
            S_RUN: begin
                // A timeout wins over a press that arrives in the same cycle.
                if (end_reached) begin
                    miss_d  = 1'b1;
                    round_d = round_q + 1'b1;
                    state_d = S_RESULT;
                end else if (response) begin
                    hit_d   = 1'b1;
                    score_d = (score_q == '1) ? score_q : score_q + 1'b1;
                    round_d = round_q + 1'b1;
`ifdef ROUND_CTRL_BEST_EN
                    last_d  = timer_value;
                    if (timer_value < best_q) best_d = timer_value;
`endif
                    state_d = S_RESULT;
                end
            end
            // round_q already carries the count that includes the round just scored.
            S_RESULT:  state_d = (round_q == ROUNDS_C) ? S_DONE : S_ARM_GAP;
            S_ARM_GAP: state_d = S_GAP;
            S_GAP:     if (end_reached) state_d = S_ARM_WIN;
            default:   state_d = S_IDLE;
        endcase

        tr_d   = 1'b1;
        en_d   = 1'b0;
        tdif_d = 2'd0;
        tend_d = 12'd0;
        ra_d   = 1'b0;
        go_d   = 1'b0;
        case (state_d)
            S_ARM_WIN: begin
                tdif_d = dif_d;
                tend_d = WIN_END_C;
            end
            S_RUN: begin
                tr_d   = 1'b0;
                en_d   = 1'b1;
                tdif_d = dif_d;
                tend_d = WIN_END_C;
                ra_d   = 1'b1;
            end
            S_RESULT: begin
                tr_d   = 1'b0;
                tdif_d = tdif_q;
                tend_d = tend_q;
            end
            S_ARM_GAP: tend_d = GAP_END_C;
            S_GAP: begin
                tr_d   = 1'b0;
                en_d   = 1'b1;
                tend_d = GAP_END_C;
            end
            S_DONE:  go_d = 1'b1;
            default: ;
        endcase
    end

    // State, game counters and output registers; reset holds the timer in reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            state_q <= S_IDLE;
            dif_q   <= 2'd0;
            score_q <= '0;
            round_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            tr_q    <= 1'b1;
            en_q    <= 1'b0;
            tdif_q  <= 2'd0;
            tend_q  <= 12'd0;
            ra_q    <= 1'b0;
            go_q    <= 1'b0;
`ifdef ROUND_CTRL_BEST_EN
            last_q  <= 12'hFFF;
            best_q  <= 12'hFFF;
`endif
        end else begin
            state_q <= state_d;
            dif_q   <= dif_d;
            score_q <= score_d;
            round_q <= round_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            tr_q    <= tr_d;
            en_q    <= en_d;
            tdif_q  <= tdif_d;
            tend_q  <= tend_d;
            ra_q    <= ra_d;
            go_q    <= go_d;
`ifdef ROUND_CTRL_BEST_EN
            last_q  <= last_d;
            best_q  <= best_d;
`endif
        end
    end

    assign timer_reset      = tr_q;
    assign timer_enable     = en_q;
    assign timer_difficulty = tdif_q;
    assign timer_end_value  = tend_q;
    assign round_active     = ra_q;
    assign hit              = hit_q;
    assign miss             = miss_q;
    assign score            = score_q;
    assign round_num        = round_q;
    assign game_over        = go_q;
`ifdef ROUND_CTRL_BEST_EN
    assign last_time        = last_q;
    assign best_time        = best_q;
`endif

endmodule

// File: tb/tb_round_ctrl.sv
// tb_round_ctrl: directed game scenarios for round_ctrl, driven through a behavioural timer.
// For each game, a timeline model expands the per-round response targets into one
// expected output vector per cycle. A single compare process checks that timeline
// against the DUT on every cycle. Literal checks pin the model at key points.
module tb_round_ctrl;

    localparam int ROUNDS = 3;
    localparam int WE     = 2;
    localparam int GE     = 1;
    localparam int SW     = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    difficulty_sel = 2'd0;
    logic          response = 1'b0;
    logic [11:0]   timer_value = 12'd0;
    logic          end_reached;
    logic          timer_reset, timer_enable, round_active, hit, miss, game_over;
    logic [1:0]    timer_difficulty;
    logic [11:0]   timer_end_value;
    logic [SW-1:0] score, round_num;
`ifdef ROUND_CTRL_BEST_EN
    logic [11:0]   last_time, best_time;
`endif

    round_ctrl #(.ROUNDS(ROUNDS), .WINDOW_END(WE), .GAP_END(GE), .SCORE_W(SW)) dut (
        .clk(clk), .reset(reset), .start(start), .difficulty_sel(difficulty_sel),
        .response(response), .timer_value(timer_value), .end_reached(end_reached),
        .timer_reset(timer_reset), .timer_enable(timer_enable),
        .timer_difficulty(timer_difficulty), .timer_end_value(timer_end_value),
        .round_active(round_active), .hit(hit), .miss(miss), .score(score),
        .round_num(round_num), .game_over(game_over)
`ifdef ROUND_CTRL_BEST_EN
        , .last_time(last_time), .best_time(best_time)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural timer: synchronous reset, counts up while enabled, and stops at end_value.
    always @(posedge clk) begin
        if (timer_reset) timer_value <= 12'd0;
        else if (timer_enable && timer_value != timer_end_value) timer_value <= timer_value + 12'd1;
    end
    assign end_reached = !timer_reset && (timer_value == timer_end_value);

    typedef struct packed {
        logic        tr;
        logic        en;
        logic [1:0]  dif;
        logic [11:0] endv;
        logic        ra;
        logic        hit;
        logic        miss;
        logic [7:0]  score;
        logic [7:0]  rnd;
        logic        go;
        logic [11:0] last;
        logic [11:0] best;
    } exp_t;

    exp_t        q[$];
    int          m_score = 0;
    int          m_rnd   = 0;
    logic        m_go    = 1'b0;
    logic [11:0] m_last  = 12'hFFF;
    logic [11:0] m_best  = 12'hFFF;
    int          tg[ROUNDS];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          n_hit   = 0;
    int          n_miss  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic exp_t mk(input logic tr, input logic en, input logic [1:0] dif,
                                input int endv, input logic ra, input logic h, input logic m,
                                input int sc, input int rn, input logic go,
                                input logic [11:0] ls, input logic [11:0] bs);
        exp_t e;
        e.tr = tr; e.en = en; e.dif = dif; e.endv = 12'(endv); e.ra = ra;
        e.hit = h; e.miss = m; e.score = 8'(sc); e.rnd = 8'(rn); e.go = go;
        e.last = ls; e.best = bs;
        return e;
    endfunction

    // Outputs of a parked sequencer (IDLE or DONE) using the current model totals.
    function automatic exp_t rest();
        return mk(1'b1, 1'b0, 2'd0, 0, 1'b0, 1'b0, 1'b0, m_score, m_rnd, m_go, m_last, m_best);
    endfunction

    // Expand the game into per-cycle expectations.
    // A round whose target is below WINDOW_END is a hit, pressed at RUN cycle "target".
    // Any other round is a miss at RUN cycle WINDOW_END.
    task automatic plan_game(input logic [1:0] d);
        int          sc = 0;
        int          rn = 0;
        logic [11:0] ls = 12'hFFF;
        logic [11:0] bs = 12'hFFF;
        for (int r = 0; r < ROUNDS; r++) begin
            logic h;
            int   rl;
            h  = (tg[r] < WE);
            rl = h ? tg[r] + 1 : WE + 1;
            q.push_back(mk(1'b1, 1'b0, d, WE, 1'b0, 1'b0, 1'b0, sc, rn, 1'b0, ls, bs));
            for (int c = 0; c < rl; c++)
                q.push_back(mk(1'b0, 1'b1, d, WE, 1'b1, 1'b0, 1'b0, sc, rn, 1'b0, ls, bs));
            if (h) begin
                if (sc < 255) sc++;
                ls = 12'(tg[r]);
                if (12'(tg[r]) < bs) bs = 12'(tg[r]);
            end
            rn++;
            q.push_back(mk(1'b0, 1'b0, d, WE, 1'b0, h, !h, sc, rn, 1'b0, ls, bs));
            if (rn == ROUNDS) break;
            q.push_back(mk(1'b1, 1'b0, 2'd0, GE, 1'b0, 1'b0, 1'b0, sc, rn, 1'b0, ls, bs));
            for (int c = 0; c < GE + 1; c++)
                q.push_back(mk(1'b0, 1'b1, 2'd0, GE, 1'b0, 1'b0, 1'b0, sc, rn, 1'b0, ls, bs));
        end
        m_score = sc; m_rnd = rn; m_go = 1'b1; m_last = ls; m_best = bs;
    endtask

    // Compare process: compare the DUT with the model one time unit after every rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            e = (q.size() > 0) ? q.pop_front() : rest();
            check("timer_reset", 32'(timer_reset), 32'(e.tr));
            check("timer_enable", 32'(timer_enable), 32'(e.en));
            check("timer_difficulty", 32'(timer_difficulty), 32'(e.dif));
            check("timer_end_value", 32'(timer_end_value), 32'(e.endv));
            check("round_active", 32'(round_active), 32'(e.ra));
            check("hit", 32'(hit), 32'(e.hit));
            check("miss", 32'(miss), 32'(e.miss));
            check("score", 32'(score), 32'(e.score));
            check("round_num", 32'(round_num), 32'(e.rnd));
            check("game_over", 32'(game_over), 32'(e.go));
`ifdef ROUND_CTRL_BEST_EN
            check("last_time", 32'(last_time), 32'(e.last));
            check("best_time", 32'(best_time), 32'(e.best));
`endif
            if (hit === 1'b1) n_hit++;
            if (miss === 1'b1) n_miss++;
        end
    end

    task automatic wait_active();
        int n = 0;
        while (round_active !== 1'b1) begin
            if (n == 40) begin
                timeout("wait_round_active");
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    // Press once the window timer shows the target. Return at the first negedge after the window closes.
    task automatic run_round(input int tgt);
        int n = 0;
        wait_active();
        while (round_active === 1'b1 && n < 20) begin
            response = (timer_value == 12'(tgt));
            @(negedge clk);
            n++;
        end
        response = 1'b0;
        if (n >= 20) timeout("run_round");
    endtask

    task automatic start_game(input logic [1:0] d, input int t0, input int t1, input int t2);
        tg[0] = t0; tg[1] = t1; tg[2] = t2;
        @(negedge clk);
        difficulty_sel = d;
        start = 1'b1;
        plan_game(d);
        @(negedge clk);
        start = 1'b0;
        difficulty_sel = ~d;
    endtask

    // With noise set, the bench sends a start pulse in RESULT and a press in the GAP.
    // The DUT must ignore both.
    task automatic play_rounds(input bit noise);
        for (int r = 0; r < ROUNDS; r++) begin
            run_round(tg[r]);
            if (noise && r < ROUNDS - 1) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                @(negedge clk);
                response = 1'b1;
                @(negedge clk);
                response = 1'b0;
            end
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int h0;
        int m0;

        // 1: reset held, then released, then an early press in IDLE.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        response = 1'b1;
        @(negedge clk);
        response = 1'b0;
        @(negedge clk);
        check("t1_timer_reset", 32'(timer_reset), 32'd1);
        check("t1_score", 32'(score), 32'd0);
        check("t1_game_over", 32'(game_over), 32'd0);

        // 2: difficulty 2, and every round is hit at timer value 1.
        h0 = n_hit;
        start_game(2'd2, 1, 1, 1);
        play_rounds(1'b0);
        check("t2_hit_pulses", 32'(n_hit - h0), 32'd3);
        check("t2_score", 32'(score), 32'd3);
        check("t2_round_num", 32'(round_num), 32'd3);
        check("t2_game_over", 32'(game_over), 32'd1);

        // 3: the player never responds, so every round times out.
        m0 = n_miss;
        start_game(2'd1, 99, 99, 99);
        play_rounds(1'b0);
        check("t3_miss_pulses", 32'(n_miss - m0), 32'd3);
        check("t3_score", 32'(score), 32'd0);
        check("t3_game_over", 32'(game_over), 32'd1);

        // 4: presses land on end_reached (timeout wins), plus ignored presses and starts.
        h0 = n_hit;
        m0 = n_miss;
        start_game(2'd3, WE, 0, WE);
        play_rounds(1'b1);
        check("t4_score", 32'(score), 32'd1);
        check("t4_hit_pulses", 32'(n_hit - h0), 32'd1);
        check("t4_miss_pulses", 32'(n_miss - m0), 32'd2);

        // 5: reset asserted mid-RUN in round 2.
        start_game(2'd1, 0, 1, 1);
        run_round(0);
        wait_active();
        reset = 1'b1;
        q.delete();
        m_score = 0; m_rnd = 0; m_go = 1'b0; m_last = 12'hFFF; m_best = 12'hFFF;
        #1;
        check("t5_timer_enable", 32'(timer_enable), 32'd0);
        check("t5_timer_reset", 32'(timer_reset), 32'd1);
        check("t5_score", 32'(score), 32'd0);
        check("t5_round_active", 32'(round_active), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 6: fresh game with hits at timer values 1, 0, 1.
        start_game(2'd0, 1, 0, 1);
        play_rounds(1'b0);
        check("t6_score", 32'(score), 32'd3);
`ifdef ROUND_CTRL_BEST_EN
        check("t6_last_time", 32'(last_time), 32'd1);
        check("t6_best_time", 32'(best_time), 32'd0);
`endif
        start_game(2'd2, 99, 0, 99);
`ifdef ROUND_CTRL_BEST_EN
        check("t6_last_cleared", 32'(last_time), 32'hFFF);
        check("t6_best_cleared", 32'(best_time), 32'hFFF);
`endif
        check("t6_round_num_cleared", 32'(round_num), 32'd0);
        play_rounds(1'b0);
        check("t6_final_score", 32'(score), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
